ifetch_prefetch_unit: RTL and testbench

//  Front-end fetch stage feeding the IF/ID register of the RV32I pipeline.
//  - Generates sequential word fetch addresses and issues them to a variable-latency instruction memory over a valid/ready request channel.
//  - Buffers returned words with their PCs in a small prefetch FIFO.
//  - Presents them to decode through a valid/ready handshake.
//  - Handles redirects (taken branch, EX stage) by flushing buffered words and discarding in-flight responses.

---
 rtl/riscv_pkg.sv | 6 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/ifetch_prefetch_unit.sv | 91 +++++++++
 tb/tb_ifetch_prefetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants for the front-end
package riscv_pkg;
    localparam int          XLEN       = 32;
    localparam int          INSN_BYTES = 4;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with flush and simultaneous push/pop at full
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & !flush & (count != '0);
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push & !flush & (!full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/ifetch_prefetch_unit.sv
// rtl/ifetch_prefetch_unit.sv - sequential instruction prefetcher with redirect flush
module ifetch_prefetch_unit #(
    parameter int              XLEN            = riscv_pkg::XLEN,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [31:0]     inst_data
);
    import riscv_pkg::*;

    localparam int              CNT_W   = $clog2(FIFO_DEPTH+1);
    localparam logic [XLEN-1:0] STEP    = XLEN'(INSN_BYTES);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTSTANDING);

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    rsp_pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   credit_used;
    logic [XLEN+31:0]   fifo_head;
    logic [XLEN-1:0]    head_pc;
    logic [31:0]        head_data;
    logic [XLEN-1:0]    target_pc;
    logic               req_fire;
    logic               rsp_keep;
    logic               pop;

    // Outstanding requests reserve FIFO slots, so a returning word always fits.
    assign credit_used   = outstanding + fifo_count;
    assign mem_req_valid = !reset && !redirect_valid && (outstanding < MAX_C) && (credit_used < DEPTH_C);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid & mem_req_ready;
    assign rsp_keep      = mem_rsp_valid & (drop_cnt == '0) & !redirect_valid;
    assign target_pc     = redirect_pc & ~(STEP - XLEN'(1));

    assign inst_valid    = (fifo_count != '0);
    assign pop           = inst_valid & inst_ready & !redirect_valid;
    assign {head_pc, head_data} = fifo_head;
    assign inst_pc       = head_pc;
    assign inst_data     = inst_valid ? head_data : NOP_INSN;

    fetch_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_keep),
        .push_data ({rsp_pc, mem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(mem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                // Everything still in flight belongs to the abandoned path.
                drop_cnt <= outstanding - CNT_W'(mem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + STEP;
                if (rsp_keep) rsp_pc   <= rsp_pc + STEP;
                if (mem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// tb/tb_ifetch_prefetch_unit.sv - scoreboard bench for ifetch_prefetch_unit
module tb_ifetch_prefetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    always #5 clk = ~clk;

    ifetch_prefetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data)
    );

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; int due; } req_t;

    exp_t        sb[$];
    req_t        pend[$];
    logic [31:0] popped[$];
    logic [31:0] reqs[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_checks = 0;
    int          n_pass = 0;
    int          fires = 0;
    int          pops = 0;
    logic [31:0] exp_fetch = '0;
    logic [31:0] last_pc = '0;
    bit          have_last = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A3C_0F93;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // One clock: observe handshakes at negedge, then play the memory after posedge.
    task automatic cycle();
        bit   fire, pop, redir;
        exp_t e;
        @(negedge clk);
        fire  = mem_req_valid & mem_req_ready;
        pop   = inst_valid & inst_ready;
        redir = redirect_valid;
        if (mem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
        if (redir) begin
            check("no_req_on_redirect", 32'(mem_req_valid), 0);
            sb.delete();
            have_last = 0;
            exp_fetch = redirect_pc & ~32'h3;
        end else if (pop) begin
            pops++;
            popped.push_back(inst_pc);
            if (sb.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                e = sb.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst_data", inst_data, e.data);
            end
            if (have_last) check("pc_step", inst_pc, last_pc + 32'd4);
            last_pc   = inst_pc;
            have_last = 1;
        end
        if (fire) begin
            check("req_addr", mem_req_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            fires++;
            reqs.push_back(mem_req_addr);
            pend.push_back('{addr: mem_req_addr, due: cyc + lat});
            sb.push_back('{pc: mem_req_addr, data: mem_word(mem_req_addr)});
            check("max_outstanding", 32'(pend.size() <= 2), 1);
            check("credit", 32'(sb.size() <= 4), 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            pend.delete();
            mem_rsp_valid = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        sb.delete();
        pend.delete();
        popped.delete();
        reqs.delete();
        mem_rsp_valid = 1'b0;
        have_last = 0;
        exp_fetch = '0;
        repeat (2) cycle();
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_req_valid", 32'(mem_req_valid), 0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        reset = 1'b0;
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        #1;
        cycle();
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        int p0, f0, k;
        logic [31:0] held;

        // Sequential fetch with 1-cycle memory
        lat = 1;
        do_reset();
        check("t1_first_req_valid", 32'(mem_req_valid), 1);
        check("t1_first_addr", mem_req_addr, 32'h0);
        repeat (10) cycle();
        check("t1_pc0", popped.size() > 2 ? popped[0] : 32'hFFFF_FFFF, 32'h0);
        check("t1_pc1", popped.size() > 2 ? popped[1] : 32'hFFFF_FFFF, 32'h4);
        check("t1_pc2", popped.size() > 2 ? popped[2] : 32'hFFFF_FFFF, 32'h8);
        p0 = pops;
        repeat (20) cycle();
        check("t1_no_gaps", pops - p0, 20);

        // Decode stall fills the FIFO, then drains in order
        inst_ready = 1'b0;
        do_reset();
        f0 = fires;
        repeat (12) cycle();
        check("t2_req_count", fires - f0, 4);
        check("t2_req_valid_low", 32'(mem_req_valid), 0);
        check("t2_inst_valid", 32'(inst_valid), 1);
        inst_ready = 1'b1;
        popped.delete();
        reqs.delete();
        repeat (8) cycle();
        for (int i = 0; i < 4; i++)
            check("t2_drain_pc", popped.size() > i ? popped[i] : 32'hFFFF_FFFF, 32'(4 * i));
        check("t2_resume_addr", reqs.size() > 0 ? reqs[0] : 32'hFFFF_FFFF, 32'h10);

        // Redirect with two requests in flight, 3-cycle memory
        lat = 3;
        do_reset();
        k = 0;
        while (pend.size() < 2 && k < 20) begin
            cycle();
            k++;
        end
        check("t3_two_outstanding", pend.size(), 2);
        popped.delete();
        redirect(32'h1C);
        repeat (20) cycle();
        check("t3_first_pc", popped.size() > 1 ? popped[0] : 32'hFFFF_FFFF, 32'h1C);
        check("t3_second_pc", popped.size() > 1 ? popped[1] : 32'hFFFF_FFFF, 32'h20);

        // Back-to-back redirects while drops are still pending
        popped.delete();
        redirect(32'h100);
        cycle();
        redirect(32'h200);
        repeat (20) cycle();
        check("t3b_first_pc", popped.size() > 0 ? popped[0] : 32'hFFFF_FFFF, 32'h200);

        // Misaligned redirect and redirect-to-instruction latency
        lat = 1;
        repeat (10) cycle();
        redirect(32'h1E);
        check("t4_req_addr", mem_req_addr, 32'h1C);
        check("t4_req_valid", 32'(mem_req_valid), 1);
        check("t4_inst_valid_c1", 32'(inst_valid), 0);
        cycle();
        check("t4_inst_valid_c2", 32'(inst_valid), 0);
        cycle();
        check("t4_inst_valid_c3", 32'(inst_valid), 1);
        check("t4_inst_pc", inst_pc, 32'h1C);
        repeat (10) cycle();

        // Memory backpressure holds the request
        mem_req_ready = 1'b0;
        held = mem_req_addr;
        repeat (5) begin
            cycle();
            check("t5_addr_stable", mem_req_addr, held);
            check("t5_valid_held", 32'(mem_req_valid), 1);
        end
        check("t5_fifo_drained", 32'(inst_valid), 0);
        reqs.delete();
        mem_req_ready = 1'b1;
        repeat (10) cycle();
        check("t5_resume_addr", reqs.size() > 0 ? reqs[0] : 32'hFFFF_FFFF, held);

        // Address wrap at the top of the space
        popped.delete();
        reqs.delete();
        redirect(32'hFFFF_FFF8);
        repeat (10) cycle();
        check("t6_req0", reqs.size() > 2 ? reqs[0] : 32'h1, 32'hFFFF_FFF8);
        check("t6_req1", reqs.size() > 2 ? reqs[1] : 32'h1, 32'hFFFF_FFFC);
        check("t6_req2", reqs.size() > 2 ? reqs[2] : 32'h1, 32'h0000_0000);
        check("t6_pc0", popped.size() > 2 ? popped[0] : 32'h1, 32'hFFFF_FFF8);
        check("t6_pc1", popped.size() > 2 ? popped[1] : 32'h1, 32'hFFFF_FFFC);
        check("t6_pc2", popped.size() > 2 ? popped[2] : 32'h1, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
